// File: rtl/decode_pkg.sv
// Shared definitions for the decode/issue stage.
//   - RV32I major opcodes
//   - op_type codes carried to ROB/RS/LSB (6 bits)
//   - issue FSM state enum
//   - is_lsb_op(): unit routing helper
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    typedef logic [5:0] op_t;

    localparam op_t OP_LUI     = 6'd0;
    localparam op_t OP_AUIPC   = 6'd1;
    localparam op_t OP_JAL     = 6'd2;
    localparam op_t OP_JALR    = 6'd3;
    localparam op_t OP_BEQ     = 6'd4;
    localparam op_t OP_BNE     = 6'd5;
    localparam op_t OP_BLT     = 6'd6;
    localparam op_t OP_BGE     = 6'd7;
    localparam op_t OP_BLTU    = 6'd8;
    localparam op_t OP_BGEU    = 6'd9;
    localparam op_t OP_LB      = 6'd10;
    localparam op_t OP_LH      = 6'd11;
    localparam op_t OP_LW      = 6'd12;
    localparam op_t OP_LBU     = 6'd13;
    localparam op_t OP_LHU     = 6'd14;
    localparam op_t OP_SB      = 6'd15;
    localparam op_t OP_SH      = 6'd16;
    localparam op_t OP_SW      = 6'd17;
    localparam op_t OP_ADDI    = 6'd18;
    localparam op_t OP_SLTI    = 6'd19;
    localparam op_t OP_SLTIU   = 6'd20;
    localparam op_t OP_XORI    = 6'd21;
    localparam op_t OP_ORI     = 6'd22;
    localparam op_t OP_ANDI    = 6'd23;
    localparam op_t OP_SLLI    = 6'd24;
    localparam op_t OP_SRLI    = 6'd25;
    localparam op_t OP_SRAI    = 6'd26;
    localparam op_t OP_ADD     = 6'd28;
    localparam op_t OP_SUB     = 6'd29;
    localparam op_t OP_SLL     = 6'd30;
    localparam op_t OP_SLT     = 6'd31;
    localparam op_t OP_SLTU    = 6'd32;
    localparam op_t OP_XOR     = 6'd33;
    localparam op_t OP_SRL     = 6'd34;
    localparam op_t OP_SRA     = 6'd35;
    localparam op_t OP_OR      = 6'd36;
    localparam op_t OP_AND     = 6'd37;
    localparam op_t OP_ILLEGAL = 6'd40;

    typedef enum logic {
        RUN       = 1'b0,
        JALR_WAIT = 1'b1
    } state_t;

    // Loads and stores go to the LSB; everything else (illegal included) to the RS.
    function automatic logic is_lsb_op(input op_t op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Combinational RV32I field decoder.
//   inst, pc          : instruction word and its address
//   op_type           : decode_pkg op code (OP_ILLEGAL for anything unlisted)
//   rd, rs1, rs2      : register indices, zeroed where the format has none
//   imm               : format immediate (AUIPC already has pc added)
//   to_rs, to_lsb     : one-hot destination unit
module inst_field_decode
    import decode_pkg::*;
#(
    parameter int REG_ID_BIT = 5
) (
    input  logic [31:0]           inst,
    input  logic [31:0]           pc,
    output op_t                   op_type,
    output logic [REG_ID_BIT-1:0] rd,
    output logic [REG_ID_BIT-1:0] rs1,
    output logic [REG_ID_BIT-1:0] rs2,
    output logic [31:0]           imm,
    output logic                  to_rs,
    output logic                  to_lsb
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic        use_rd, use_rs1, use_rs2;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_sh = {27'b0, inst[24:20]};

    always_comb begin
        op_type = OP_ILLEGAL;
        imm     = '0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OPC_LUI: begin
                op_type = OP_LUI;
                imm     = imm_u;
                use_rd  = 1'b1;
            end
            OPC_AUIPC: begin
                op_type = OP_AUIPC;
                imm     = pc + imm_u;
                use_rd  = 1'b1;
            end
            OPC_JAL: begin
                op_type = OP_JAL;
                imm     = imm_j;
                use_rd  = 1'b1;
            end
            OPC_JALR: begin
                if (funct3 == 3'd0) begin
                    op_type = OP_JALR;
                    imm     = imm_i;
                    use_rd  = 1'b1;
                    use_rs1 = 1'b1;
                end
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'd0:    op_type = OP_BEQ;
                    3'd1:    op_type = OP_BNE;
                    3'd4:    op_type = OP_BLT;
                    3'd5:    op_type = OP_BGE;
                    3'd6:    op_type = OP_BLTU;
                    3'd7:    op_type = OP_BGEU;
                    default: op_type = OP_ILLEGAL;
                endcase
                if (op_type != OP_ILLEGAL) begin
                    imm     = imm_b;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
            end
            OPC_LOAD: begin
                case (funct3)
                    3'd0:    op_type = OP_LB;
                    3'd1:    op_type = OP_LH;
                    3'd2:    op_type = OP_LW;
                    3'd4:    op_type = OP_LBU;
                    3'd5:    op_type = OP_LHU;
                    default: op_type = OP_ILLEGAL;
                endcase
                if (op_type != OP_ILLEGAL) begin
                    imm     = imm_i;
                    use_rd  = 1'b1;
                    use_rs1 = 1'b1;
                end
            end
            OPC_STORE: begin
                case (funct3)
                    3'd0:    op_type = OP_SB;
                    3'd1:    op_type = OP_SH;
                    3'd2:    op_type = OP_SW;
                    default: op_type = OP_ILLEGAL;
                endcase
                if (op_type != OP_ILLEGAL) begin
                    imm     = imm_s;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                case (funct3)
                    3'd0: op_type = OP_ADDI;
                    3'd2: op_type = OP_SLTI;
                    3'd3: op_type = OP_SLTIU;
                    3'd4: op_type = OP_XORI;
                    3'd6: op_type = OP_ORI;
                    3'd7: op_type = OP_ANDI;
                    3'd1: op_type = (funct7 == 7'h00) ? OP_SLLI : OP_ILLEGAL;
                    3'd5: op_type = (funct7 == 7'h00) ? OP_SRLI :
                                    (funct7 == 7'h20) ? OP_SRAI : OP_ILLEGAL;
                    default: op_type = OP_ILLEGAL;
                endcase
                if (op_type != OP_ILLEGAL) begin
                    // Shifts carry only the 5-bit shamt, never the funct7 bits.
                    imm     = (funct3 == 3'd1 || funct3 == 3'd5) ? imm_sh : imm_i;
                    use_rd  = 1'b1;
                    use_rs1 = 1'b1;
                end
            end
            OPC_OP: begin
                case ({funct7, funct3})
                    {7'h00, 3'd0}: op_type = OP_ADD;
                    {7'h20, 3'd0}: op_type = OP_SUB;
                    {7'h00, 3'd1}: op_type = OP_SLL;
                    {7'h00, 3'd2}: op_type = OP_SLT;
                    {7'h00, 3'd3}: op_type = OP_SLTU;
                    {7'h00, 3'd4}: op_type = OP_XOR;
                    {7'h00, 3'd5}: op_type = OP_SRL;
                    {7'h20, 3'd5}: op_type = OP_SRA;
                    {7'h00, 3'd6}: op_type = OP_OR;
                    {7'h00, 3'd7}: op_type = OP_AND;
                    default:       op_type = OP_ILLEGAL;
                endcase
                if (op_type != OP_ILLEGAL) begin
                    use_rd  = 1'b1;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
            end
            default: op_type = OP_ILLEGAL;
        endcase
    end

    assign rd     = use_rd  ? REG_ID_BIT'(inst[11:7])  : '0;
    assign rs1    = use_rs1 ? REG_ID_BIT'(inst[19:15]) : '0;
    assign rs2    = use_rs2 ? REG_ID_BIT'(inst[24:20]) : '0;
    assign to_lsb = is_lsb_op(op_type);
    assign to_rs  = !to_lsb;

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: takes one instruction-queue entry, decodes it and holds
// it in a single output register until ROB and the selected RS/LSB take it.
//   clk_in, rst_in (async, active-high), rdy_in (global pause)
//   if_valid/if_pc/if_inst/if_ready : instruction-queue handshake
//   clear                           : mispredict flush
//   rob_full/rs_full/lsb_full       : downstream back-pressure
//   rob_free_id -> rob_tag          : ROB tag for the held entry
//   out_valid/to_rs/to_lsb + fields : issued instruction
//   jalr_done/jalr_target           : JALR resolution from execute
//   redirect_valid/redirect_pc      : one-cycle fetch redirect
// Build option: define DECODE_BTFN_EN for backward-taken/forward-not-taken
// branch prediction; default build predicts every branch not-taken.
module decode_issue
    import decode_pkg::*;
#(
    parameter int REG_ID_BIT    = 5,
    parameter int ROB_WIDTH_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     if_valid,
    input  logic [31:0]              if_pc,
    input  logic [31:0]              if_inst,
    output logic                     if_ready,
    input  logic                     clear,
    input  logic                     rob_full,
    input  logic                     rs_full,
    input  logic                     lsb_full,
    input  logic [ROB_WIDTH_BIT-1:0] rob_free_id,
    output logic [ROB_WIDTH_BIT-1:0] rob_tag,
    output logic                     out_valid,
    output logic                     to_rs,
    output logic                     to_lsb,
    output logic [5:0]               op_type,
    output logic [REG_ID_BIT-1:0]    rd,
    output logic [REG_ID_BIT-1:0]    rs1,
    output logic [REG_ID_BIT-1:0]    rs2,
    output logic [31:0]              imm,
    output logic [31:0]              inst_pc,
    output logic                     pred_taken,
    input  logic                     jalr_done,
    input  logic [31:0]              jalr_target,
    output logic                     redirect_valid,
    output logic [31:0]              redirect_pc
);

`ifdef DECODE_BTFN_EN
    localparam bit BTFN_EN = 1'b1;
`else
    localparam bit BTFN_EN = 1'b0;
`endif

    op_t                   dec_op;
    logic [REG_ID_BIT-1:0] dec_rd, dec_rs1, dec_rs2;
    logic [31:0]           dec_imm;
    logic                  dec_to_rs, dec_to_lsb;

    inst_field_decode #(.REG_ID_BIT(REG_ID_BIT)) u_dec (
        .inst    (if_inst),
        .pc      (if_pc),
        .op_type (dec_op),
        .rd      (dec_rd),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .imm     (dec_imm),
        .to_rs   (dec_to_rs),
        .to_lsb  (dec_to_lsb)
    );

    state_t      state, state_d;
    logic        accept, load;
    logic        dec_branch, dec_pred;
    logic [31:0] jump_target;
    logic        redirect_d;
    logic [31:0] redirect_pc_d;

    assign accept   = out_valid && !rob_full && !(to_rs ? rs_full : lsb_full);
    // rst_in term keeps if_ready low during reset, since it is combinational.
    assign if_ready = rdy_in && !rst_in && (state == RUN) && (!out_valid || accept) && !clear;
    assign load     = if_valid && if_ready;

    // The held entry's tag is whatever the ROB would allocate when it accepts.
    assign rob_tag  = out_valid ? rob_free_id : '0;

    assign dec_branch  = (dec_op >= OP_BEQ) && (dec_op <= OP_BGEU);
    // JAL is always redirected at decode, so it never reports a prediction.
    assign dec_pred    = BTFN_EN && dec_branch && dec_imm[31];
    // Valid for JAL (imm_j) and branches (imm_b) only.
    assign jump_target = if_pc + dec_imm;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= RUN;
        else        state <= state_d;
    end

    always_comb begin
        state_d       = state;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc;
        if (clear) begin
            state_d = RUN;
        end else if (rdy_in) begin
            case (state)
                RUN: begin
                    if (load && dec_op == OP_JALR) state_d = JALR_WAIT;
                    if (load && (dec_op == OP_JAL || dec_pred)) begin
                        redirect_d    = 1'b1;
                        redirect_pc_d = jump_target;
                    end
                end
                JALR_WAIT: begin
                    if (jalr_done) begin
                        state_d       = RUN;
                        redirect_d    = 1'b1;
                        redirect_pc_d = jalr_target & ~32'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= redirect_d;
            redirect_pc    <= redirect_pc_d;
        end
    end

    // Output entry: fields change only on load, so they stay put while stalled.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_valid  <= 1'b0;
            to_rs      <= 1'b0;
            to_lsb     <= 1'b0;
            op_type    <= '0;
            rd         <= '0;
            rs1        <= '0;
            rs2        <= '0;
            imm        <= '0;
            inst_pc    <= '0;
            pred_taken <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (rdy_in) begin
            if (load) begin
                out_valid  <= 1'b1;
                to_rs      <= dec_to_rs;
                to_lsb     <= dec_to_lsb;
                op_type    <= dec_op;
                rd         <= dec_rd;
                rs1        <= dec_rs1;
                rs2        <= dec_rs2;
                imm        <= dec_imm;
                inst_pc    <= if_pc;
                pred_taken <= dec_pred;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
module tb_decode_issue;
    import decode_pkg::*;

`ifdef DECODE_BTFN_EN
    localparam bit BTFN = 1'b1;
`else
    localparam bit BTFN = 1'b0;
`endif

    logic        clk_in, rst_in, rdy_in;
    logic        if_valid, if_ready;
    logic [31:0] if_pc, if_inst;
    logic        clear, rob_full, rs_full, lsb_full;
    logic [3:0]  rob_free_id, rob_tag;
    logic        out_valid, to_rs, to_lsb, pred_taken;
    logic [5:0]  op_type;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, inst_pc;
    logic        jalr_done, redirect_valid;
    logic [31:0] jalr_target, redirect_pc;

    int checks = 0;
    int errors = 0;

    decode_issue dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
        .clear(clear), .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .rob_free_id(rob_free_id), .rob_tag(rob_tag),
        .out_valid(out_valid), .to_rs(to_rs), .to_lsb(to_lsb),
        .op_type(op_type), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .inst_pc(inst_pc), .pred_taken(pred_taken),
        .jalr_done(jalr_done), .jalr_target(jalr_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic test_reset();
        rst_in = 1'b1;
        #1;
        checks++;
        if ({if_ready, rob_tag, out_valid, to_rs, to_lsb, op_type, rd, rs1, rs2, imm,
             inst_pc, pred_taken, redirect_valid, redirect_pc} !== '0) begin
            errors++; $display("FAIL reset_outputs: some output nonzero (out_valid=%0b op=%0d imm=%0h)", out_valid, op_type, imm);
        end
        checks++;
        if (dut.state !== RUN) begin errors++; $display("FAIL reset_state got %0d exp 0", dut.state); end
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic test_addi();
        if_pc = 32'h0; if_inst = 32'h00500093; if_valid = 1'b1; rob_free_id = 4'd5;
        #1;
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL addi_if_ready got %0b exp 1", if_ready); end
        @(negedge clk_in);
        if_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0b exp 1", out_valid); end
        checks++; if (op_type !== 6'd18) begin errors++; $display("FAIL addi_op got %0d exp 18", op_type); end
        checks++; if ({rd, rs1, rs2} !== {5'd1, 5'd0, 5'd0}) begin errors++; $display("FAIL addi_regs got %0d/%0d/%0d exp 1/0/0", rd, rs1, rs2); end
        checks++; if (imm !== 32'd5) begin errors++; $display("FAIL addi_imm got %0h exp 5", imm); end
        checks++; if ({to_rs, to_lsb} !== 2'b10) begin errors++; $display("FAIL addi_unit got %b exp 10", {to_rs, to_lsb}); end
        checks++; if (rob_tag !== 4'd5) begin errors++; $display("FAIL addi_rob_tag got %0d exp 5", rob_tag); end
        @(negedge clk_in);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got %0b exp 0", out_valid); end
    endtask

    task automatic test_sw_stall();
        lsb_full = 1'b1;
        if_pc = 32'h40; if_inst = 32'h0020A423; if_valid = 1'b1;
        @(negedge clk_in);
        // Next entry waits behind the stalled store.
        if_pc = 32'h44; if_inst = 32'h00500093;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL sw_if_ready[%0d] got %0b exp 0", i, if_ready); end
            checks++;
            if ({out_valid, op_type, rd, rs1, rs2, imm, inst_pc, to_lsb, to_rs} !==
                {1'b1, 6'd17, 5'd0, 5'd1, 5'd2, 32'd8, 32'h40, 1'b1, 1'b0}) begin
                errors++; $display("FAIL sw_hold[%0d] got v=%0b op=%0d rd=%0d rs1=%0d rs2=%0d imm=%0h lsb=%0b exp 1/17/0/1/2/8/1",
                                   i, out_valid, op_type, rd, rs1, rs2, imm, to_lsb);
            end
            if (i < 3) @(negedge clk_in);
        end
        lsb_full = 1'b0;
        #1;
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL sw_release_ready got %0b exp 1", if_ready); end
        @(negedge clk_in);
        if_valid = 1'b0;
        checks++; if ({out_valid, op_type, inst_pc} !== {1'b1, 6'd18, 32'h44}) begin
            errors++; $display("FAIL sw_next_load got v=%0b op=%0d pc=%0h exp 1/18/44", out_valid, op_type, inst_pc); end
        @(negedge clk_in);
    endtask

    task automatic test_beq();
        if_pc = 32'h100; if_inst = 32'hFE000CE3; if_valid = 1'b1;
        @(negedge clk_in);
        if_valid = 1'b0;
        checks++; if ({out_valid, op_type, rd, imm} !== {1'b1, 6'd4, 5'd0, 32'hFFFFFFF8}) begin
            errors++; $display("FAIL beq_fields got v=%0b op=%0d rd=%0d imm=%0h exp 1/4/0/fffffff8", out_valid, op_type, rd, imm); end
        checks++; if (pred_taken !== BTFN) begin errors++; $display("FAIL beq_pred got %0b exp %0b", pred_taken, BTFN); end
        checks++; if (redirect_valid !== BTFN) begin errors++; $display("FAIL beq_redirect got %0b exp %0b", redirect_valid, BTFN); end
        if (BTFN) begin
            checks++; if (redirect_pc !== 32'hF8) begin errors++; $display("FAIL beq_redirect_pc got %0h exp f8", redirect_pc); end
        end
        @(negedge clk_in);
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL beq_pulse_end got %0b exp 0", redirect_valid); end
    endtask

    task automatic test_jal();
        if_pc = 32'h200; if_inst = 32'h010000EF; if_valid = 1'b1;
        @(negedge clk_in);
        if_valid = 1'b0;
        checks++; if ({op_type, rd, rs1, imm, pred_taken, to_rs} !== {6'd2, 5'd1, 5'd0, 32'd16, 1'b0, 1'b1}) begin
            errors++; $display("FAIL jal_fields got op=%0d rd=%0d rs1=%0d imm=%0h pt=%0b exp 2/1/0/10/0", op_type, rd, rs1, imm, pred_taken); end
        checks++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h210}) begin
            errors++; $display("FAIL jal_redirect got %0b/%0h exp 1/210", redirect_valid, redirect_pc); end
        @(negedge clk_in);
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL jal_pulse_end got %0b exp 0", redirect_valid); end
    endtask

    task automatic test_jalr();
        if_pc = 32'h300; if_inst = 32'h000080E7; if_valid = 1'b1;
        @(negedge clk_in);
        if_pc = 32'h304; if_inst = 32'h00500093;
        #1;
        checks++; if ({op_type, rd, rs1, imm} !== {6'd3, 5'd1, 5'd1, 32'd0}) begin
            errors++; $display("FAIL jalr_fields got op=%0d rd=%0d rs1=%0d imm=%0h exp 3/1/1/0", op_type, rd, rs1, imm); end
        checks++; if (dut.state !== JALR_WAIT) begin errors++; $display("FAIL jalr_state got %0d exp 1", dut.state); end
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL jalr_if_ready got %0b exp 0", if_ready); end
        @(negedge clk_in);
        checks++; if ({if_ready, redirect_valid} !== 2'b00) begin
            errors++; $display("FAIL jalr_wait got ready=%0b redir=%0b exp 0/0", if_ready, redirect_valid); end
        jalr_done = 1'b1; jalr_target = 32'h205;
        @(negedge clk_in);
        jalr_done = 1'b0;
        #1;
        checks++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h204}) begin
            errors++; $display("FAIL jalr_redirect got %0b/%0h exp 1/204", redirect_valid, redirect_pc); end
        checks++; if ({dut.state, if_ready} !== {RUN, 1'b1}) begin
            errors++; $display("FAIL jalr_resume got state=%0d ready=%0b exp 0/1", dut.state, if_ready); end
        if_valid = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_clear_jalr();
        rob_full = 1'b1;
        if_pc = 32'h400; if_inst = 32'h000080E7; if_valid = 1'b1;
        @(negedge clk_in);
        if_valid = 1'b0;
        checks++; if ({out_valid, dut.state} !== {1'b1, JALR_WAIT}) begin
            errors++; $display("FAIL clr_setup got v=%0b state=%0d exp 1/1", out_valid, dut.state); end
        clear = 1'b1; jalr_done = 1'b1; jalr_target = 32'h999;
        @(negedge clk_in);
        clear = 1'b0; jalr_done = 1'b0; rob_full = 1'b0;
        checks++; if ({out_valid, redirect_valid, dut.state} !== {1'b0, 1'b0, RUN}) begin
            errors++; $display("FAIL clr_result got v=%0b redir=%0b state=%0d exp 0/0/0", out_valid, redirect_valid, dut.state); end
        @(negedge clk_in);
    endtask

    task automatic test_rdy_pause();
        rdy_in = 1'b0;
        if_pc = 32'h500; if_inst = 32'h010000EF; if_valid = 1'b1;
        #1;
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL pause_ready got %0b exp 0", if_ready); end
        @(negedge clk_in);
        checks++; if ({out_valid, redirect_valid} !== 2'b00) begin
            errors++; $display("FAIL pause_hold got v=%0b redir=%0b exp 0/0", out_valid, redirect_valid); end
        rdy_in = 1'b1;
        @(negedge clk_in);
        if_valid = 1'b0;
        checks++; if ({out_valid, op_type, redirect_valid, redirect_pc} !== {1'b1, 6'd2, 1'b1, 32'h510}) begin
            errors++; $display("FAIL pause_resume got v=%0b op=%0d redir=%0b/%0h exp 1/2/1/510", out_valid, op_type, redirect_valid, redirect_pc); end
        @(negedge clk_in);
    endtask

    task automatic test_back_to_back();
        logic [31:0] t_inst [5] = '{32'h123450B7, 32'h00001117, 32'h402081B3, 32'h40335293, 32'hFFC12203};
        logic [31:0] t_pc   [5] = '{32'h0, 32'h1000, 32'h8, 32'hC, 32'h10};
        logic [5:0]  t_op   [5] = '{6'd0, 6'd1, 6'd29, 6'd26, 6'd12};
        logic [31:0] t_imm  [5] = '{32'h12345000, 32'h2000, 32'h0, 32'h3, 32'hFFFFFFFC};
        logic [4:0]  t_rd   [5] = '{5'd1, 5'd2, 5'd3, 5'd5, 5'd4};
        logic [4:0]  t_rs1  [5] = '{5'd0, 5'd0, 5'd1, 5'd6, 5'd2};
        logic [4:0]  t_rs2  [5] = '{5'd0, 5'd0, 5'd2, 5'd0, 5'd0};
        logic        t_lsb  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        if_pc = t_pc[0]; if_inst = t_inst[0]; if_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            checks++;
            if ({out_valid, op_type, imm, rd, rs1, rs2, to_lsb, to_rs, inst_pc} !==
                {1'b1, t_op[i], t_imm[i], t_rd[i], t_rs1[i], t_rs2[i], t_lsb[i], !t_lsb[i], t_pc[i]}) begin
                errors++; $display("FAIL b2b[%0d] got v=%0b op=%0d imm=%0h rd=%0d rs1=%0d rs2=%0d lsb=%0b exp op=%0d imm=%0h rd=%0d rs1=%0d rs2=%0d lsb=%0b",
                                   i, out_valid, op_type, imm, rd, rs1, rs2, to_lsb, t_op[i], t_imm[i], t_rd[i], t_rs1[i], t_rs2[i], t_lsb[i]);
            end
            if (i < 4) begin if_pc = t_pc[i+1]; if_inst = t_inst[i+1]; end
            else if_valid = 1'b0;
        end
        @(negedge clk_in);
    endtask

    task automatic test_reset_mid_stall();
        lsb_full = 1'b1;
        if_pc = 32'h600; if_inst = 32'h0020A423; if_valid = 1'b1;
        @(negedge clk_in);
        if_valid = 1'b0;
        checks++; if ({out_valid, op_type} !== {1'b1, 6'd17}) begin
            errors++; $display("FAIL rst_setup got v=%0b op=%0d exp 1/17", out_valid, op_type); end
        #2 rst_in = 1'b1;
        #1;
        checks++;
        if ({if_ready, rob_tag, out_valid, to_rs, to_lsb, op_type, rd, rs1, rs2, imm,
             inst_pc, pred_taken, redirect_valid, redirect_pc} !== '0) begin
            errors++; $display("FAIL rst_async: output nonzero (v=%0b op=%0d imm=%0h pc=%0h)", out_valid, op_type, imm, inst_pc);
        end
        @(negedge clk_in);
        rst_in = 1'b0; lsb_full = 1'b0;
        if_pc = 32'h700; if_inst = 32'hFFFFFFFF; if_valid = 1'b1;
        @(negedge clk_in);
        if_valid = 1'b0;
        checks++; if ({out_valid, op_type, to_rs, to_lsb} !== {1'b1, 6'd40, 1'b1, 1'b0}) begin
            errors++; $display("FAIL illegal got v=%0b op=%0d rs=%0b lsb=%0b exp 1/40/1/0", out_valid, op_type, to_rs, to_lsb); end
        @(negedge clk_in);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; if_valid = 1'b0; if_pc = '0; if_inst = '0;
        clear = 1'b0; rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        rob_free_id = '0; jalr_done = 1'b0; jalr_target = '0;
        test_reset();
        test_addi();
        test_sw_stall();
        test_beq();
        test_jal();
        test_jalr();
        test_clear_jalr();
        test_rdy_pause();
        test_back_to_back();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have parameter REG_ID_BIT, default 5, meaning architectural register-index width.
REQ-002 SHALL have parameter ROB_WIDTH_BIT, default 4, meaning ROB tag width, passed through on rob_tag.
REQ-003 SHALL have ports clk_in input 1, the single clock; rst_in input 1, reset that is asynchronous and active-high; rdy_in input 1, pause when low.
REQ-004 SHALL have ports if_valid input 1, if_pc input 32 and if_inst input 32 (instruction-queue entry), and if_ready output 1, meaning decoder accepts the entry this cycle.
REQ-005 SHALL have ports clear input 1 (ROB mispredict flush), plus rob_full, rs_full and lsb_full, each input 1, meaning the downstream unit is full.
REQ-006 SHALL have ports rob_free_id input ROB_WIDTH_BIT and rob_tag output ROB_WIDTH_BIT, meaning the ROB tag bound at issue.
REQ-007 SHALL have ports out_valid output 1 (to ROB), to_rs output 1 and to_lsb output 1.
REQ-008 SHALL have decoded-field output ports op_type 6, rd/rs1/rs2 REG_ID_BIT, imm 32, inst_pc 32 and pred_taken 1.
REQ-009 SHALL have ports jalr_done input 1 and jalr_target input 32 (JALR resolved), plus redirect_valid output 1 and redirect_pc output 32 (to fetch).

Function
REQ-010 SHALL hold one output entry; accept = out_valid && !rob_full && !(to_rs ? rs_full : lsb_full).
REQ-011 SHALL drive if_ready = rdy_in && state==RUN && (!out_valid || accept) && !clear.
REQ-012 SHALL load the output register 1 cycle after the if_valid&&if_ready handshake, keeping all outputs stable while out_valid && !accept.
REQ-013 SHALL encode op_type as LUI 0, AUIPC 1, JAL 2, JALR 3, BEQ..BGEU 4..9, LB,LH,LW,LBU,LHU 10..14, SB,SH,SW 15..17, ADDI,SLTI,SLTIU,XORI,ORI,ANDI 18..23, SLLI,SRLI,SRAI 24..26, ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND 28..37, and any unlisted opcode/funct3 as 40.
REQ-014 SHALL route op_type 10..17 with to_lsb=1 and all others, including 40, with to_rs=1, keeping to_rs and to_lsb mutually exclusive.
REQ-015 SHALL form imm as LUI imm_u; AUIPC pc+imm_u; JAL imm_j; JALR/loads/ALU-I imm_i; branches imm_b; stores imm_s; shifts zero-extended shamt; R-type 0 (all mod 2^32).
REQ-016 SHALL output rd=0 for stores/branches, rs2=0 for non-R/S/B, and rs1=0 for LUI/AUIPC/JAL, with inst_pc=pc always.
REQ-017 SHALL pulse redirect_valid 1 cycle with redirect_pc=pc+imm_j in the load cycle of a JAL, and SHALL clear the JAL's pred_taken.
REQ-018 SHALL use a state machine RUN -> JALR_WAIT on issue of JALR, and JALR_WAIT -> RUN on jalr_done, pulsing redirect with redirect_pc = jalr_target & ~1.
REQ-019 SHALL give clear priority over everything, so that next cycle out_valid=0, state=RUN, no redirect, and simultaneous jalr_done is ignored.
REQ-020 SHALL freeze all state when rdy_in=0, holding outputs and suppressing redirect pulses.

Reset
REQ-021 SHALL on rst_in immediately zero every output and set state to RUN, with if_ready=0 while rst_in is high.

Configuration
REQ-022 SHALL, with macro DECODE_BTFN_EN defined, predict branches with imm_b[31]=1 as taken, setting pred_taken=1 and redirecting to pc+imm_b; without it, all branches SHALL have pred_taken=0 and no redirect.

Structure
REQ-023 SHALL put opcode constants, op_type codes and the state enum in shared package decode_pkg.
REQ-024 SHALL use combinational sub-module inst_field_decode (inst, pc -> op_type, regs, imm, unit select).

Verification
REQ-025 SHALL cover the ADDI case: 0x00500093 at pc 0x0 -> op_type 18, rd 1, rs1 0, imm 5, to_rs=1, 1-cycle latency.
REQ-026 SHALL cover the SW case: 0x0020A423 with lsb_full=1 for 3 cycles -> op_type 17, rd 0, rs1 1, rs2 2, imm 8 held stable, if_ready=0, and acceptance on the cycle lsb_full drops.
REQ-027 SHALL cover the BEQ case: 0xFE000CE3 at pc 0x100 -> with DECODE_BTFN_EN, pred_taken 1 and redirect 0xF8; without it, pred_taken 0 and no redirect.
REQ-028 SHALL cover the JALR case: 0x000080E7 -> JALR_WAIT with if_ready=0; then jalr_done with target 0x205 -> redirect 0x204 and RUN.
REQ-029 SHALL cover clear and jalr_done asserted together in JALR_WAIT -> no redirect, out_valid 0, state RUN.
REQ-030 SHALL cover rst_in asserted mid-stall -> outputs zero asynchronously, and 0xFFFFFFFF after reset -> op_type 40 via RS.
